// File: rtl/l2_cache_miss_sequencer_pkg.sv
// l2_cache_miss_sequencer_pkg: line geometry and state type shared by the L2 miss sequencer
package l2_cache_miss_sequencer_pkg;
  localparam int CACHE_LINE_BITS = 512;
  localparam int LINE_ADR_BITS = 26;
  typedef logic [LINE_ADR_BITS-1:0] cache_line_index_t;
  typedef enum logic [1:0] {IDLE, READ_REQ, READ_DATA, FILL} l2_miss_state_t;
endpackage

// File: rtl/l2_cache_miss_sequencer_sync_fifo.sv
// l2_cache_miss_sequencer_sync_fifo: in-order miss queue, head visible the cycle after a push
module l2_cache_miss_sequencer_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int SIZE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(SIZE);
  localparam logic [AW:0] SIZE_CNT = SIZE[AW:0];
  logic [WIDTH-1:0] mem [SIZE];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  // full is taken from the registered count, so a same-cycle pop never makes room for a push
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign empty = count == '0;
  assign full = count == SIZE_CNT;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/l2_cache_miss_sequencer.sv
// l2_cache_miss_sequencer: queues L2 misses, reads each non-duplicate line from memory and
// presents fills to the arbiter strictly in order; duplicates replay without a memory read.
module l2_cache_miss_sequencer
  import l2_cache_miss_sequencer_pkg::*;
#(
  parameter int QUEUE_SIZE = 8,
  parameter int BUS_WIDTH = 32,
  parameter int REQ_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enqueue_valid,
  input  cache_line_index_t          enqueue_adr,
  input  logic                       enqueue_duplicate,
  input  logic [REQ_WIDTH-1:0]       enqueue_payload,
  output logic                       queue_full,
  output logic                       mem_read_valid,
  output cache_line_index_t          mem_read_adr,
  input  logic                       mem_read_ready,
  input  logic                       mem_rdata_valid,
  input  logic [BUS_WIDTH-1:0]       mem_rdata,
  output logic                       fill_valid,
  output cache_line_index_t          fill_adr,
  output logic [CACHE_LINE_BITS-1:0] fill_data,
  output logic                       fill_duplicate,
  output logic [REQ_WIDTH-1:0]       fill_payload,
  input  logic                       fill_ack
);
  localparam int BEATS = CACHE_LINE_BITS / BUS_WIDTH;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int EW = $bits(cache_line_index_t) + 1 + REQ_WIDTH;
  l2_miss_state_t state;
  logic [BW-1:0] beat;
  logic [EW-1:0] head;
  cache_line_index_t head_adr;
  logic head_dup, empty, pop;
  logic [REQ_WIDTH-1:0] head_payload;
  assign {head_adr, head_dup, head_payload} = head;
  assign pop = state == FILL && fill_ack;
  l2_cache_miss_sequencer_sync_fifo #(.WIDTH(EW), .SIZE(QUEUE_SIZE)) u_queue (
    .clk(clk),
    .reset(reset),
    .push(enqueue_valid),
    .pop(pop),
    .wdata({enqueue_adr, enqueue_duplicate, enqueue_payload}),
    .rdata(head),
    .empty(empty),
    .full(queue_full)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      beat <= '0;
      fill_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) state <= head_dup ? FILL : READ_REQ;
          beat <= '0;
        end
        READ_REQ: if (mem_read_ready) state <= READ_DATA;
        READ_DATA: if (mem_rdata_valid) begin
          fill_data[beat*BUS_WIDTH +: BUS_WIDTH] <= mem_rdata;
          beat <= beat + 1'b1;
          if (beat == BW'(BEATS-1)) state <= FILL;
        end
        FILL: if (fill_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign mem_read_valid = state == READ_REQ;
  assign mem_read_adr = mem_read_valid ? head_adr : '0;
  assign fill_valid = state == FILL;
  assign fill_adr = fill_valid ? head_adr : '0;
  assign fill_payload = fill_valid ? head_payload : '0;
  assign fill_duplicate = fill_valid && head_dup;
  // protocol violations are reported but not fatal: the offending input is simply dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(enqueue_valid && queue_full)) else $warning("miss dropped: queue full");
      assert (!(mem_rdata_valid && state != READ_DATA)) else $warning("read beat outside READ_DATA ignored");
    end
  end
endmodule

// File: tb/tb_l2_cache_miss_sequencer.sv
// tb_l2_cache_miss_sequencer: directed table, corner sequences and randomized model check
module tb_l2_cache_miss_sequencer;
  import l2_cache_miss_sequencer_pkg::*;
  localparam int QS = 8;
  localparam int BUSW = 32;
  localparam int RW = 64;
  localparam int BEATS = CACHE_LINE_BITS / BUSW;
  logic clk = 0, reset = 1;
  logic enqueue_valid = 0, enqueue_duplicate = 0, mem_read_ready = 0, mem_rdata_valid = 0, fill_ack = 0;
  cache_line_index_t enqueue_adr = '0, mem_read_adr, fill_adr;
  logic [RW-1:0] enqueue_payload = '0, fill_payload;
  logic [BUSW-1:0] mem_rdata = '0;
  logic [CACHE_LINE_BITS-1:0] fill_data;
  logic queue_full, mem_read_valid, fill_valid, fill_duplicate;
  int passed = 0, total = 0, rd_cnt = 0;
  l2_cache_miss_sequencer #(.QUEUE_SIZE(QS), .BUS_WIDTH(BUSW), .REQ_WIDTH(RW)) dut (
    .clk(clk), .reset(reset),
    .enqueue_valid(enqueue_valid), .enqueue_adr(enqueue_adr),
    .enqueue_duplicate(enqueue_duplicate), .enqueue_payload(enqueue_payload),
    .queue_full(queue_full),
    .mem_read_valid(mem_read_valid), .mem_read_adr(mem_read_adr), .mem_read_ready(mem_read_ready),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_adr(fill_adr), .fill_data(fill_data),
    .fill_duplicate(fill_duplicate), .fill_payload(fill_payload), .fill_ack(fill_ack)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_read_valid && mem_read_ready) rd_cnt++;
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  typedef struct {
    logic ev;
    cache_line_index_t adr;
    logic e_full;
    logic e_rv;
    cache_line_index_t e_radr;
  } vec_t;
  typedef struct {
    cache_line_index_t adr;
    logic dup;
    logic [RW-1:0] pay;
  } ent_t;
  function automatic logic [BUSW-1:0] word(input cache_line_index_t a, input int k);
    return {a[15:0] ^ 16'h0100, 16'(k)};
  endfunction
  function automatic logic [CACHE_LINE_BITS-1:0] line(input cache_line_index_t a);
    logic [CACHE_LINE_BITS-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*BUSW +: BUSW] = word(a, k);
    return l;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic chk_line(input string name, input logic [CACHE_LINE_BITS-1:0] act, input logic [CACHE_LINE_BITS-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic enq(input cache_line_index_t a, input logic d, input logic [RW-1:0] p);
    enqueue_valid = 1;
    enqueue_adr = a;
    enqueue_duplicate = d;
    enqueue_payload = p;
    tick();
    enqueue_valid = 0;
  endtask
  task automatic serve(input cache_line_index_t a, input int nb);
    int n = 0;
    while (!mem_read_valid && n < 40) begin tick(); n++; end
    chk("read request seen", mem_read_valid, 1);
    chk("mem_read_adr", mem_read_adr, a);
    mem_read_ready = 1;
    tick();
    mem_read_ready = 0;
    for (int k = 0; k < nb; k++) begin
      mem_rdata_valid = 1;
      mem_rdata = word(a, k);
      tick();
    end
    mem_rdata_valid = 0;
  endtask
  task automatic fill_take(input cache_line_index_t a, input logic d, input logic [RW-1:0] p);
    int n = 0;
    while (!fill_valid && n < 40) begin tick(); n++; end
    chk("fill seen", fill_valid, 1);
    chk("fill_adr", fill_adr, a);
    chk("fill_duplicate", fill_duplicate, d);
    chk("fill_payload", fill_payload, p);
    if (!d) chk_line("fill_data", fill_data, line(a));
    fill_ack = 1;
    tick();
    fill_ack = 0;
  endtask
  vec_t tbl[10];
  ent_t q[$];
  initial begin
    int r0;
    logic reading, head_read;
    int rbeat, fills;
    cache_line_index_t radr, a;
    tbl[0] = '{1, 26'h1, 0, 0, 26'h0};
    tbl[1] = '{1, 26'h2, 0, 0, 26'h0};
    for (int i = 2; i < 8; i++) tbl[i] = '{1, cache_line_index_t'(i + 1), 0, 1, 26'h1};
    tbl[8] = '{1, 26'h9, 1, 1, 26'h1};
    tbl[9] = '{0, 26'h0, 1, 1, 26'h1};
    tick(); tick();
    chk("reset queue_full", queue_full, 0);
    chk("reset mem_read_valid", mem_read_valid, 0);
    chk("reset mem_read_adr", mem_read_adr, 0);
    chk("reset fill_valid", fill_valid, 0);
    chk("reset fill_adr", fill_adr, 0);
    chk("reset fill_duplicate", fill_duplicate, 0);
    chk("reset fill_payload", fill_payload, 0);
    chk_line("reset fill_data", fill_data, '0);
    reset = 0;
    // single miss at minimum latency, beat k carries value k
    enq(26'h100, 0, 64'hA1);
    chk("latency idle", mem_read_valid, 0);
    tick();
    chk("latency read_req", mem_read_valid, 1);
    chk("first mem_read_adr", mem_read_adr, 26'h100);
    mem_read_ready = 1;
    tick();
    mem_read_ready = 0;
    for (int k = 0; k < BEATS; k++) begin
      mem_rdata_valid = 1;
      mem_rdata = BUSW'(k);
      tick();
    end
    mem_rdata_valid = 0;
    chk("latency fill", fill_valid, 1);
    chk("first fill_adr", fill_adr, 26'h100);
    chk("first data low beat", fill_data[31:0], 0);
    chk("first data top beat", fill_data[511:480], 15);
    chk("first fill_duplicate", fill_duplicate, 0);
    chk("first fill_payload", fill_payload, 64'hA1);
    fill_ack = 1;
    tick();
    fill_ack = 0;
    chk("fill drops after ack", fill_valid, 0);
    // original plus duplicate: one memory read, two ordered fills
    r0 = rd_cnt;
    enq(26'h100, 0, 64'hB2);
    enq(26'h100, 1, 64'hC3);
    serve(26'h100, BEATS);
    fill_take(26'h100, 0, 64'hB2);
    fill_take(26'h100, 1, 64'hC3);
    chk("single read for duplicate", rd_cnt - r0, 1);
    tick(); tick();
    // fill the queue with memory stalled; the ninth miss is dropped
    for (int i = 0; i < 10; i++) begin
      enqueue_valid = tbl[i].ev;
      enqueue_adr = tbl[i].adr;
      enqueue_duplicate = 0;
      enqueue_payload = RW'(tbl[i].adr) * 3;
      chk("tbl queue_full", queue_full, tbl[i].e_full);
      chk("tbl mem_read_valid", mem_read_valid, tbl[i].e_rv);
      chk("tbl mem_read_adr", mem_read_adr, tbl[i].e_radr);
      tick();
    end
    enqueue_valid = 0;
    serve(26'h1, BEATS);
    for (int i = 0; i < 5; i++) begin
      chk("hold fill_valid", fill_valid, 1);
      chk("hold fill_adr", fill_adr, 26'h1);
      chk("hold no read", mem_read_valid, 0);
      tick();
    end
    chk("full before ack", queue_full, 1);
    chk_line("held fill_data", fill_data, line(26'h1));
    enqueue_valid = 1;
    enqueue_adr = 26'hA;
    enqueue_duplicate = 0;
    fill_ack = 1;
    tick();
    enqueue_valid = 0;
    fill_ack = 0;
    chk("full after ack+enq", queue_full, 0);
    chk("fill gone after ack", fill_valid, 0);
    for (int i = 2; i <= 8; i++) begin
      serve(cache_line_index_t'(i), BEATS);
      fill_take(cache_line_index_t'(i), 0, RW'(i) * 3);
    end
    for (int i = 0; i < 5; i++) tick();
    chk("drained no read", mem_read_valid, 0);
    chk("drained no fill", fill_valid, 0);
    // reset in the middle of a line read
    enq(26'h5, 0, 64'h55);
    serve(26'h5, 4);
    reset = 1;
    tick();
    reset = 0;
    chk("midreset queue_full", queue_full, 0);
    chk("midreset mem_read_valid", mem_read_valid, 0);
    chk("midreset mem_read_adr", mem_read_adr, 0);
    chk("midreset fill_valid", fill_valid, 0);
    chk("midreset fill_adr", fill_adr, 0);
    chk("midreset fill_payload", fill_payload, 0);
    chk("midreset fill_duplicate", fill_duplicate, 0);
    chk_line("midreset fill_data", fill_data, '0);
    tick(); tick(); tick();
    chk("midreset queue empty", mem_read_valid, 0);
    enq(26'h2, 0, 64'h22);
    serve(26'h2, BEATS);
    fill_take(26'h2, 0, 64'h22);
    // randomized traffic against an in-order queue model and a backing memory model
    reading = 0;
    head_read = 0;
    rbeat = 0;
    radr = '0;
    fills = 0;
    for (int c = 0; c < 8000; c++) begin
      if (c >= 5000 && q.size() == 0 && !reading) break;
      chk("rand queue_full", queue_full, q.size() == QS);
      if (mem_read_valid) begin
        chk("rand read for new head", q.size() > 0 && !q[0].dup && !reading && !head_read, 1);
        chk("rand mem_read_adr", mem_read_adr, q.size() > 0 ? q[0].adr : '0);
      end
      mem_read_ready = $urandom_range(0, 1) == 1;
      mem_rdata_valid = reading && $urandom_range(0, 2) != 0;
      mem_rdata = word(radr, rbeat);
      fill_ack = fill_valid ? $urandom_range(0, 1) == 1 : $urandom_range(0, 3) == 0;
      enqueue_valid = c < 5000 && q.size() < QS && $urandom_range(0, 2) == 0;
      a = cache_line_index_t'(32'h20 + $urandom_range(0, 3));
      enqueue_adr = a;
      enqueue_duplicate = 0;
      foreach (q[i]) if (q[i].adr == a) enqueue_duplicate = 1;
      enqueue_payload = {$urandom, $urandom};
      if (fill_valid && fill_ack) begin
        chk("rand fill has head", q.size() > 0, 1);
        if (q.size() > 0) begin
          chk("rand fill_adr", fill_adr, q[0].adr);
          chk("rand fill_duplicate", fill_duplicate, q[0].dup);
          chk("rand fill_payload", fill_payload, q[0].pay);
          if (!q[0].dup) begin
            chk("rand line complete", head_read && !reading, 1);
            chk_line("rand fill_data", fill_data, line(q[0].adr));
          end
          void'(q.pop_front());
        end
        head_read = 0;
        fills++;
      end
      if (enqueue_valid) q.push_back('{enqueue_adr, enqueue_duplicate, enqueue_payload});
      if (mem_read_valid && mem_read_ready) begin
        reading = 1;
        rbeat = 0;
        head_read = 1;
        radr = mem_read_adr == (q.size() > 0 ? q[0].adr : '0) ? mem_read_adr : '0;
      end else if (mem_rdata_valid) begin
        rbeat++;
        if (rbeat == BEATS) reading = 0;
      end
      tick();
    end
    enqueue_valid = 0;
    mem_read_ready = 0;
    mem_rdata_valid = 0;
    fill_ack = 0;
    chk("rand queue drained", q.size(), 0);
    chk("rand fills happened", fills > 100, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
